// File: rtl/xmw_pipe_ctrl_pkg.sv
// Shared constants for the X/M/W pipeline controller: opcodes, bubble encoding,
// operand-select encodings, FSM states and source-register usage decode.
package pipe_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_PC  = 2'b01;
   localparam logic [1:0] SEL_IMM = 2'b10;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_FREEZE = 2'd1;
   localparam logic [1:0] ST_BRANCH = 2'd2;
   localparam logic [1:0] ST_BUBBLE = 2'd3;

   // U-type and JAL carry immediate bits where rs1 would be.
   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/xmw_pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: a non-x0 load in X whose rd feeds a source
// register the Decode instruction really reads.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [6:0] x_opcode,
   input  logic [4:0] x_rd,
   input  logic [6:0] d_opcode,
   input  logic [4:0] d_rs1,
   input  logic [4:0] d_rs2,
   output logic       lu
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = uses_rs1(d_opcode) && (d_rs1 == x_rd);
   assign rs2_hit = uses_rs2(d_opcode) && (d_rs2 == x_rd);
   assign lu      = (x_opcode == OPC_LOAD) && (x_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/xmw_pipe_ctrl.sv
// X/M/W pipeline registers with freeze / branch-squash / load-use bubble control.
// Optional performance counters are built when XMW_PERF_CNT_EN is defined.
module xmw_pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int                 AWIDTH = 32,
   parameter logic [AWIDTH-1:0]  NOP    = NOP_INSTR
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] Instr_D,
   input  logic [1:0]        ASelD,
   input  logic [1:0]        BSelD,
   input  logic              RegWEnD,
   input  logic              BrTakenX,
   input  logic              DMemReady,
   output logic [AWIDTH-1:0] Instr_X,
   output logic [AWIDTH-1:0] Instr_M,
   output logic [AWIDTH-1:0] Instr_W,
   output logic [1:0]        ASelE,
   output logic [1:0]        BSelE,
   output logic              RegWEnM,
   output logic              RegWEnW,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD
`ifdef XMW_PERF_CNT_EN
   ,
   output logic [31:0]       StallCnt,
   output logic [31:0]       FlushCnt
`endif
);

   logic       reg_wen_x;
   logic       lu;
   logic [1:0] state;
   logic [1:0] decision;

   hazard_detect u_hazard_detect (
      .x_opcode (Instr_X[6:0]),
      .x_rd     (Instr_X[11:7]),
      .d_opcode (Instr_D[6:0]),
      .d_rs1    (Instr_D[19:15]),
      .d_rs2    (Instr_D[24:20]),
      .lu       (lu)
   );

   // A bubble always pushes the load into M, so a second bubble in a row is
   // never legitimate; the registered state refuses it.
   always_comb begin
      decision = ST_RUN;
      if (!rst_n)
         decision = ST_RUN;
      else if (!DMemReady)
         decision = ST_FREEZE;
      else if (BrTakenX)
         decision = ST_BRANCH;
      else if (lu && (state != ST_BUBBLE))
         decision = ST_BUBBLE;
   end

   assign StallF = (decision == ST_FREEZE) || (decision == ST_BUBBLE);
   assign StallD = StallF;
   assign FlushD = (decision == ST_BRANCH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         Instr_X   <= NOP;
         Instr_M   <= NOP;
         Instr_W   <= NOP;
         ASelE     <= SEL_REG;
         BSelE     <= SEL_REG;
         reg_wen_x <= 1'b0;
         RegWEnM   <= 1'b0;
         RegWEnW   <= 1'b0;
      end else begin
         state <= decision;
         case (decision)
            ST_RUN: begin
               Instr_X   <= Instr_D;
               ASelE     <= ASelD;
               BSelE     <= BSelD;
               reg_wen_x <= RegWEnD;
               Instr_M   <= Instr_X;
               RegWEnM   <= reg_wen_x;
               Instr_W   <= Instr_M;
               RegWEnW   <= RegWEnM;
            end
            ST_BRANCH, ST_BUBBLE: begin
               Instr_X   <= NOP;
               ASelE     <= SEL_REG;
               BSelE     <= SEL_REG;
               reg_wen_x <= 1'b0;
               Instr_M   <= Instr_X;
               RegWEnM   <= reg_wen_x;
               Instr_W   <= Instr_M;
               RegWEnW   <= RegWEnM;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef XMW_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         StallCnt <= 32'd0;
         FlushCnt <= 32'd0;
      end else begin
         if (decision == ST_BUBBLE)
            StallCnt <= StallCnt + 32'd1;
         if (decision == ST_BRANCH)
            FlushCnt <= FlushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xmw_pipe_ctrl.sv
// Scoreboard bench for xmw_pipe_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_xmw_pipe_ctrl;

   localparam logic [31:0] N     = 32'h0000_0013;
   localparam logic [31:0] LW5   = 32'h0000_A283;
   localparam logic [31:0] ADD6  = 32'h0022_8333;
   localparam logic [31:0] LW0   = 32'h0000_A003;
   localparam logic [31:0] ADD60 = 32'h0020_0333;
   localparam logic [31:0] LUI5  = 32'h0002_82B7;
   localparam logic [31:0] ADDI7 = 32'h0050_8393;
   localparam logic [31:0] JAL1  = 32'h0000_00EF;

   typedef struct {
      logic        rst;
      logic [31:0] d;
      logic [1:0]  as;
      logic [1:0]  bs;
      logic        we;
      logic        br;
      logic        rdy;
      logic [31:0] ix;
      logic [31:0] im;
      logic [31:0] iw;
      logic [1:0]  ase;
      logic [1:0]  bse;
      logic        wm;
      logic        ww;
      logic        sf;
      logic        sd;
      logic        fd;
      logic [31:0] sc;
      logic [31:0] fc;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] Instr_D;
   logic [1:0]  ASelD;
   logic [1:0]  BSelD;
   logic        RegWEnD;
   logic        BrTakenX;
   logic        DMemReady;
   logic [31:0] Instr_X;
   logic [31:0] Instr_M;
   logic [31:0] Instr_W;
   logic [1:0]  ASelE;
   logic [1:0]  BSelE;
   logic        RegWEnM;
   logic        RegWEnW;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
`ifdef XMW_PERF_CNT_EN
   logic [31:0] StallCnt;
   logic [31:0] FlushCnt;
`endif

   vec_t vec_q[$];
   vec_t sb[$];
   int   applied = 0;
   int   miscompares = 0;
   logic prev_bubble = 1'b0;

   xmw_pipe_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Instr_D   (Instr_D),
      .ASelD     (ASelD),
      .BSelD     (BSelD),
      .RegWEnD   (RegWEnD),
      .BrTakenX  (BrTakenX),
      .DMemReady (DMemReady),
      .Instr_X   (Instr_X),
      .Instr_M   (Instr_M),
      .Instr_W   (Instr_W),
      .ASelE     (ASelE),
      .BSelE     (BSelE),
      .RegWEnM   (RegWEnM),
      .RegWEnW   (RegWEnW),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD)
`ifdef XMW_PERF_CNT_EN
      ,
      .StallCnt  (StallCnt),
      .FlushCnt  (FlushCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input logic rst, input logic [31:0] d, input logic [1:0] as, input logic [1:0] bs,
                         input logic we, input logic br, input logic rdy,
                         input logic [31:0] ix, input logic [31:0] im, input logic [31:0] iw,
                         input logic [1:0] ase, input logic [1:0] bse, input logic wm, input logic ww,
                         input logic sf, input logic sd, input logic fd,
                         input logic [31:0] sc, input logic [31:0] fc);
      vec_t v;
      v.rst = rst; v.d = d; v.as = as; v.bs = bs; v.we = we; v.br = br; v.rdy = rdy;
      v.ix = ix; v.im = im; v.iw = iw; v.ase = ase; v.bse = bse; v.wm = wm; v.ww = ww;
      v.sf = sf; v.sd = sd; v.fd = fd; v.sc = sc; v.fc = fc;
      vec_q.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n     = v.rst;
      Instr_D   = v.d;
      ASelD     = v.as;
      BSelD     = v.bs;
      RegWEnD   = v.we;
      BrTakenX  = v.br;
      DMemReady = v.rdy;
      sb.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every cycle carrying a pending expectation is compared mid-cycle.
   always @(negedge clk) begin
      vec_t e;
      logic bubble_now;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("Instr_X", Instr_X, e.ix);
         checkOutput("Instr_M", Instr_M, e.im);
         checkOutput("Instr_W", Instr_W, e.iw);
         checkOutput("ASelE",   {30'd0, ASelE}, {30'd0, e.ase});
         checkOutput("BSelE",   {30'd0, BSelE}, {30'd0, e.bse});
         checkOutput("RegWEnM", {31'd0, RegWEnM}, {31'd0, e.wm});
         checkOutput("RegWEnW", {31'd0, RegWEnW}, {31'd0, e.ww});
         checkOutput("StallF",  {31'd0, StallF}, {31'd0, e.sf});
         checkOutput("StallD",  {31'd0, StallD}, {31'd0, e.sd});
         checkOutput("FlushD",  {31'd0, FlushD}, {31'd0, e.fd});
`ifdef XMW_PERF_CNT_EN
         checkOutput("StallCnt", StallCnt, e.sc);
         checkOutput("FlushCnt", FlushCnt, e.fc);
`endif
      end
      bubble_now = rst_n && DMemReady && StallD;
      if (prev_bubble && bubble_now) begin
         applied++;
         miscompares++;
         $display("[TB] FAIL double_bubble: got 2 consecutive bubble cycles, expected at most 1");
      end
      prev_bubble = bubble_now;
   end

   initial begin
      //      rst d      as bs we br rdy   ix     im     iw     ase bse wm ww  sf sd fd  sc fc
      addVec(0, N,     0, 0, 0, 0, 1,   N,     N,     N,     0,  0,  0, 0,  0, 0, 0,  0, 0);
      addVec(1, LW5,   0, 2, 1, 0, 1,   N,     N,     N,     0,  0,  0, 0,  0, 0, 0,  0, 0);
      addVec(1, ADD6,  0, 0, 1, 0, 1,   LW5,   N,     N,     0,  2,  0, 0,  1, 1, 0,  0, 0);
      addVec(1, ADD6,  0, 0, 1, 0, 1,   N,     LW5,   N,     0,  0,  1, 0,  0, 0, 0,  1, 0);
      addVec(1, LW0,   0, 2, 1, 0, 1,   ADD6,  N,     LW5,   0,  0,  0, 1,  0, 0, 0,  1, 0);
      addVec(1, ADD60, 0, 0, 1, 0, 1,   LW0,   ADD6,  N,     0,  2,  1, 0,  0, 0, 0,  1, 0);
      addVec(1, LW5,   0, 2, 1, 0, 1,   ADD60, LW0,   ADD6,  0,  0,  1, 1,  0, 0, 0,  1, 0);
      addVec(1, LUI5,  0, 2, 1, 0, 1,   LW5,   ADD60, LW0,   0,  2,  1, 1,  0, 0, 0,  1, 0);
      addVec(1, LW5,   0, 2, 1, 0, 1,   LUI5,  LW5,   ADD60, 0,  2,  1, 1,  0, 0, 0,  1, 0);
      addVec(1, ADDI7, 0, 2, 1, 0, 1,   LW5,   LUI5,  LW5,   0,  2,  1, 1,  0, 0, 0,  1, 0);
      addVec(1, LW5,   0, 2, 1, 0, 1,   ADDI7, LW5,   LUI5,  0,  2,  1, 1,  0, 0, 0,  1, 0);
      addVec(1, ADD6,  0, 0, 1, 1, 1,   LW5,   ADDI7, LW5,   0,  2,  1, 1,  0, 0, 1,  1, 0);
      addVec(1, N,     0, 0, 0, 0, 1,   N,     LW5,   ADDI7, 0,  0,  1, 1,  0, 0, 0,  1, 1);
      addVec(1, ADD6,  1, 2, 1, 0, 1,   N,     N,     LW5,   0,  0,  0, 1,  0, 0, 0,  1, 1);
      addVec(1, JAL1,  1, 2, 1, 0, 1,   ADD6,  N,     N,     1,  2,  0, 0,  0, 0, 0,  1, 1);
      addVec(1, LW5,   0, 2, 1, 0, 0,   JAL1,  ADD6,  N,     1,  2,  1, 0,  1, 1, 0,  1, 1);
      addVec(1, LW5,   0, 2, 1, 1, 0,   JAL1,  ADD6,  N,     1,  2,  1, 0,  1, 1, 0,  1, 1);
      addVec(1, LW5,   0, 2, 1, 0, 0,   JAL1,  ADD6,  N,     1,  2,  1, 0,  1, 1, 0,  1, 1);
      addVec(1, LW5,   0, 2, 1, 1, 1,   JAL1,  ADD6,  N,     1,  2,  1, 0,  0, 0, 1,  1, 1);
      addVec(1, ADD6,  0, 0, 1, 0, 1,   N,     JAL1,  ADD6,  0,  0,  1, 1,  0, 0, 0,  1, 2);
      addVec(1, LW5,   0, 2, 1, 0, 0,   ADD6,  N,     JAL1,  0,  0,  0, 1,  1, 1, 0,  1, 2);
      addVec(0, LW5,   0, 2, 1, 0, 0,   ADD6,  N,     JAL1,  0,  0,  0, 1,  0, 0, 0,  1, 2);
      addVec(1, N,     0, 0, 0, 0, 1,   N,     N,     N,     0,  0,  0, 0,  0, 0, 0,  0, 0);

      rst_n     = 1'b0;
      Instr_D   = N;
      ASelD     = 2'b00;
      BSelD     = 2'b00;
      RegWEnD   = 1'b0;
      BrTakenX  = 1'b0;
      DMemReady = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vec_q[i]) begin
         @(posedge clk);
         #1;
         applyStimulus(vec_q[i]);
      end

      for (int t = 0; t < 20 && sb.size() > 0; t++)
         @(posedge clk);
      if (sb.size() > 0) begin
         applied++;
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/xmw_pipe_ctrl.md
# xmw_pipe_ctrl

Execute/Memory/Writeback pipeline register and hazard controller for the five-stage RV32I core. It captures the decoded instruction and its control bits from the Decode stage and advances them through X, M and W. It produces the `Instr_X/M/W`, `ASelE/BSelE` and `RegWEnM/W` signals that the forwarding control unit consumes. It also detects load-use hazards, squashes wrong-path instructions on taken branches, and freezes the pipeline while data memory is busy.

## Interface
- `AWIDTH`, 32, instruction width.
- `NOP`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `Instr_D` in AWIDTH: instruction in Decode.
- `ASelD`, `BSelD` in 2: operand selects from the decoder.
- `RegWEnD` in 1: register write enable from the decoder.
- `BrTakenX` in 1: branch/jump in X resolved taken this cycle.
- `DMemReady` in 1: data memory can complete its access this cycle.
- `Instr_X`, `Instr_M`, `Instr_W` out AWIDTH: registered stage instructions.
- `ASelE`, `BSelE` out 2: registered operand selects for X.
- `RegWEnM`, `RegWEnW` out 1: registered write enables.
- `StallF`, `StallD` out 1: hold the PC and the F/D register.
- `FlushD` out 1: F/D register loads NOP on the next edge.

## Operation
- Internal register `RegWEnX` forms the write-enable chain D→X→M→W.
- Load-use hazard (`LU`), evaluated combinationally. All of the following hold:
  - `Instr_X[6:0]==7'h03`
  - `Instr_X[11:7]!=0`
  - rd matches a source register that `Instr_D` actually uses:
    - rs1 `[19:15]`: used unless opcode is 7'h37, 7'h17 or 7'h6F.
    - rs2 `[24:20]`: used only for opcodes 7'h33, 7'h23, 7'h63.
- Priority per cycle is FREEZE > BRANCH > LU > RUN.
- FSM, with the state registered from the previous cycle's decision:
  - **RUN**: D→X, X→M, M→W; `StallF=StallD=FlushD=0`.
  - **FREEZE** (`DMemReady=0`):
    - All X/M/W registers hold.
    - `StallF=StallD=1`, `FlushD=0`.
    - `BrTakenX` and `LU` are ignored and re-evaluated after release.
  - **BRANCH** (`BrTakenX=1`):
    - X loads bubble: `NOP`, selects 2'b00, `RegWEnX=0`.
    - `FlushD=1`; `StallF=StallD=0`.
    - M and W advance.
  - **BUBBLE** (`LU`, no branch):
    - X loads bubble; `StallF=StallD=1`, `FlushD=0`.
    - M and W advance.
- After BUBBLE the load sits in M, so `LU` clears by construction. Two consecutive BUBBLE cycles for the same load are a design error, and the bench asserts against them.
- Reset values:
  - `Instr_X/M/W=NOP`
  - `ASelE=BSelE=2'b00`
  - `RegWEnX/M/W=0`
  - `StallF/StallD/FlushD=0`
  - FSM=RUN
- Reset mid-freeze or mid-bubble returns to RUN with all stages holding NOP.

## Timing
- All stage registers update on the rising `clk` edge; zero-cycle latency from the D inputs to the X outputs at that edge.
- `StallF`, `StallD` and `FlushD` are combinational from the current X registers, `Instr_D`, `BrTakenX` and `DMemReady`, and are valid in the same cycle.
- Load-use costs exactly one bubble; a taken branch costs two slots (D flushed, X bubbled).
- Freeze lasts as long as `DMemReady=0`. Release resumes RUN on the first cycle with `DMemReady=1`.
- A branch and a load-use in the same cycle produce BRANCH only, with no stall.

## Configuration
- `XMW_PERF_CNT_EN`: when defined, the block adds outputs `StallCnt` and `FlushCnt`, each 32 bits.
  - Both reset to 0 and wrap at 2^32.
  - `StallCnt` increments once per BUBBLE cycle; `FlushCnt` increments once per BRANCH cycle.
  - FREEZE cycles increment neither counter.
- When the macro is undefined, the ports and logic are absent and the behaviour is otherwise identical.

## Structure
- Package `pipe_pkg`:
  - Opcode constants (LOAD 7'h03, STORE 7'h23, BRANCH 7'h63, OP 7'h33, LUI, AUIPC, JAL).
  - The `NOP` constant.
  - Operand-select encodings.
  - FSM state encoding RUN/FREEZE/BRANCH/BUBBLE.
- Sub-module `hazard_detect`: combinational `LU` compare (source-usage decode plus rd match). The parent holds the registers and the FSM.

## Test plan
- Reset: `rst_n=0` for 2 cycles → `Instr_X/M/W=32'h00000013`, `RegWEnM=RegWEnW=0`, all stall/flush outputs 0.
- Load-use: `lw x5,0(x1)` (32'h0000A283) in X with `add x6,x5,x2` (32'h00228333) in D, plus `RegWEnD=1`:
  - Same cycle: `StallF=StallD=1`.
  - Next cycle: `Instr_X=NOP`, `Instr_M=32'h0000A283`.
  - Cycle after: `Instr_X=32'h00228333`, no stall.
- Load to x0 (32'h0000A003) in X with `add x6,x0,x2` in D → no stall.
- `lui x5` in D after `lw x5` → no stall (rs1 not used).
- `BrTakenX=1` with a `LU` condition also present:
  - `FlushD=1`, `StallD=0`.
  - Next cycle `Instr_X=NOP` and `RegWEnM` equals the branch's enable.
- `DMemReady=0` for 3 cycles mid-stream → X/M/W values constant, `StallF=StallD=1`; on release the sequence continues unchanged.
- With `XMW_PERF_CNT_EN`, after one load-use and one taken branch → `StallCnt=1`, `FlushCnt=1`.
